// File: rtl/lift_request_scheduler.sv
// lift_request_scheduler
//   SCAN-order lift controller stepped by a 1 s tick strobe.
//   Floor call switches are synchronised, edge-detected and latched as
//   pending calls; a four-state FSM moves the car one floor per tick,
//   opens the door for DOOR_TICKS ticks per stop and keeps travelling in
//   the current direction while calls remain that way.
//
//   Optional feature macro: LIFT_IDLE_HOME_EN -- when defined, an idle car
//   with no calls returns to floor 0 after HOME_TICKS idle ticks.
//
// Ports
//   clk_100MHz  in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   tick        in   one-cycle step strobe (held high = one step per cycle)
//   sw[15:0]    in   asynchronous floor call switches, bit i -> floor i
//   lift_num    out  current car floor
//   lift_open   out  door open
//   dir_up      out  current/last travel direction (1 = up)
//   moving      out  car is travelling (MOVE_UP or MOVE_DOWN)
//   pending     out  latched outstanding calls
module lift_request_scheduler #(
  parameter int unsigned NUM_FLOORS = 16,
  parameter int unsigned DOOR_TICKS = 3,
  parameter int unsigned HOME_TICKS = 8
) (
  input  logic        clk_100MHz,
  input  logic        rst_n,
  input  logic        tick,
  input  logic [15:0] sw,
  output logic [3:0]  lift_num,
  output logic        lift_open,
  output logic        dir_up,
  output logic        moving,
  output logic [15:0] pending
);

  if (NUM_FLOORS < 2 || NUM_FLOORS > 16) begin : g_bad_floors
    $error("NUM_FLOORS must be 2..16");
  end
  if (DOOR_TICKS < 1 || DOOR_TICKS > 15) begin : g_bad_door
    $error("DOOR_TICKS must be 1..15");
  end
  if (HOME_TICKS < 1 || HOME_TICKS > 255) begin : g_bad_home
    $error("HOME_TICKS must be 1..255");
  end

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPEN
  } state_e;

  localparam logic [15:0] FLOOR_MASK = 16'((32'd1 << NUM_FLOORS) - 32'd1);
  localparam logic [3:0]  TOP_FLOOR  = 4'(NUM_FLOORS - 1);
  localparam logic [3:0]  DOOR_LOAD  = 4'(DOOR_TICKS);

  function automatic logic [15:0] above_mask(input logic [3:0] f);
    logic [15:0] m;
    m = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i > 32'(f)) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [15:0] below_mask(input logic [3:0] f);
    logic [15:0] m;
    m = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < 32'(f)) m[i] = 1'b1;
    end
    return m;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] sync1_q, sync1_d;
  logic [15:0] sync2_q, sync2_d;
  logic [15:0] sync3_q, sync3_d;
  logic [1:0]  arm_q, arm_d;
  logic [15:0] pending_q, pending_d;
  logic [3:0]  lift_num_q, lift_num_d;
  logic        dir_up_q, dir_up_d;
  logic [3:0]  door_cnt_q, door_cnt_d;

  logic [15:0] edge_vec;
  logic [15:0] clr_vec;
  logic        here_call, up_any, dn_any;
  logic [3:0]  next_floor;

  // Decision a stationary car makes on a tick; shared by IDLE and by an
  // aborted homing move.
  state_e      idle_state;
  logic        idle_dir;
  logic [3:0]  idle_cnt;

`ifdef LIFT_IDLE_HOME_EN
  logic [7:0]  home_cnt_q, home_cnt_d;
  logic        homing_q, homing_d;
  localparam logic [7:0] HOME_LAST = 8'(HOME_TICKS - 1);
`endif

  // Synchroniser plus edge detect. The history flop only holds a valid
  // sample from the third cycle after reset release, so edges are gated
  // until then; a switch already high at release never makes a call.
  always_comb begin
    sync1_d  = sw & FLOOR_MASK;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    arm_d    = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
    edge_vec = (arm_q == 2'd3) ? (sync2_q & ~sync3_q) : '0;
  end

  always_comb begin
    here_call = pending_q[lift_num_q];
    up_any    = |(pending_q & above_mask(lift_num_q));
    dn_any    = |(pending_q & below_mask(lift_num_q));

    idle_state = IDLE;
    idle_dir   = dir_up_q;
    idle_cnt   = door_cnt_q;
    if (here_call) begin
      idle_state = DOOR_OPEN;
      idle_cnt   = DOOR_LOAD;
    end else if (up_any) begin
      idle_state = MOVE_UP;
      idle_dir   = 1'b1;
    end else if (dn_any) begin
      idle_state = MOVE_DOWN;
      idle_dir   = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    lift_num_d = lift_num_q;
    dir_up_d   = dir_up_q;
    door_cnt_d = door_cnt_q;
    next_floor = lift_num_q;
`ifdef LIFT_IDLE_HOME_EN
    home_cnt_d = (state_q == IDLE) ? home_cnt_q : '0;
    homing_d   = homing_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d    = idle_state;
          dir_up_d   = idle_dir;
          door_cnt_d = idle_cnt;
`ifdef LIFT_IDLE_HOME_EN
          home_cnt_d = '0;
          if (pending_q == '0 && lift_num_q != '0) begin
            if (home_cnt_q == HOME_LAST) begin
              state_d  = MOVE_DOWN;
              dir_up_d = 1'b0;
              homing_d = 1'b1;
            end else begin
              home_cnt_d = home_cnt_q + 8'd1;
            end
          end
`endif
        end
      end

      MOVE_UP: begin
        if (tick) begin
          if (lift_num_q == TOP_FLOOR) begin
            state_d = IDLE;
          end else begin
            next_floor = lift_num_q + 4'd1;
            lift_num_d = next_floor;
            if (pending_q[next_floor]) begin
              state_d    = DOOR_OPEN;
              door_cnt_d = DOOR_LOAD;
            end else if (~|(pending_q & above_mask(next_floor))) begin
              state_d = IDLE;
            end
          end
        end
      end

      MOVE_DOWN: begin
        if (tick) begin
`ifdef LIFT_IDLE_HOME_EN
          if (homing_q) begin
            homing_d = 1'b0;
            if (pending_q != '0) begin
              // A call aborts homing; decide from the current floor.
              state_d    = idle_state;
              dir_up_d   = idle_dir;
              door_cnt_d = idle_cnt;
            end else if (lift_num_q == '0) begin
              state_d = IDLE;
            end else begin
              lift_num_d = lift_num_q - 4'd1;
              if (lift_num_d != '0) homing_d = 1'b1;
              else                  state_d  = IDLE;
            end
          end else
`endif
          if (lift_num_q == '0) begin
            state_d = IDLE;
          end else begin
            next_floor = lift_num_q - 4'd1;
            lift_num_d = next_floor;
            if (pending_q[next_floor]) begin
              state_d    = DOOR_OPEN;
              door_cnt_d = DOOR_LOAD;
            end else if (~|(pending_q & below_mask(next_floor))) begin
              state_d = IDLE;
            end
          end
        end
      end

      DOOR_OPEN: begin
        if (edge_vec[lift_num_q]) begin
          door_cnt_d = DOOR_LOAD;
        end else if (tick) begin
          door_cnt_d = door_cnt_q - 4'd1;
          if (door_cnt_q <= 4'd1) begin
            door_cnt_d = '0;
            if (dir_up_q) begin
              if (up_any) begin
                state_d = MOVE_UP;
              end else if (dn_any) begin
                state_d  = MOVE_DOWN;
                dir_up_d = 1'b0;
              end else begin
                state_d = IDLE;
              end
            end else begin
              if (dn_any) begin
                state_d = MOVE_DOWN;
              end else if (up_any) begin
                state_d  = MOVE_UP;
                dir_up_d = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // The current floor's call is cleared whenever the car is (or becomes)
    // door-open there; clearing after setting lets the clear win.
    clr_vec   = (state_d == DOOR_OPEN) ? (16'd1 << lift_num_d) : '0;
    pending_d = (pending_q | edge_vec) & ~clr_vec;
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync3_q    <= '0;
      arm_q      <= '0;
      pending_q  <= '0;
      lift_num_q <= '0;
      dir_up_q   <= 1'b1;
      door_cnt_q <= '0;
`ifdef LIFT_IDLE_HOME_EN
      home_cnt_q <= '0;
      homing_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
      arm_q      <= arm_d;
      pending_q  <= pending_d;
      lift_num_q <= lift_num_d;
      dir_up_q   <= dir_up_d;
      door_cnt_q <= door_cnt_d;
`ifdef LIFT_IDLE_HOME_EN
      home_cnt_q <= home_cnt_d;
      homing_q   <= homing_d;
`endif
    end
  end

  assign lift_num  = lift_num_q;
  assign lift_open = (state_q == DOOR_OPEN);
  assign moving    = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
  assign dir_up    = dir_up_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_lift_request_scheduler.sv
// Testbench for lift_request_scheduler (default build, homing disabled).
// A procedural lift model tracks calls, car position, door time and
// direction; the DUT outputs are compared with it every cycle.
module tb_lift_request_scheduler;

  localparam int NF = 16;
  localparam int DT = 3;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DOWN = 2;
  localparam int M_DOOR = 3;

  logic        clk_100MHz = 1'b0;
  logic        rst_n;
  logic        tick;
  logic [15:0] sw;
  logic [3:0]  lift_num;
  logic        lift_open;
  logic        dir_up;
  logic        moving;
  logic [15:0] pending;

  lift_request_scheduler #(
    .NUM_FLOORS(NF),
    .DOOR_TICKS(DT),
    .HOME_TICKS(8)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .rst_n     (rst_n),
    .tick      (tick),
    .sw        (sw),
    .lift_num  (lift_num),
    .lift_open (lift_open),
    .dir_up    (dir_up),
    .moving    (moving),
    .pending   (pending)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int checks   = 0;
  int failures = 0;

  // Model state
  int          m_mode;
  int          m_floor;
  bit          m_dir;
  logic [15:0] m_pend;
  int          m_door;
  logic [15:0] hist[$];

  logic [15:0] cur_sw;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit any_above(input logic [15:0] p, input int f);
    for (int i = f + 1; i < NF; i++) if (p[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_below(input logic [15:0] p, input int f);
    for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_floor = 0;
    m_dir   = 1'b1;
    m_pend  = '0;
    m_door  = 0;
    hist.delete();
  endtask

  // One clock edge of lift behaviour. A call is registered two edges after
  // the switch is first seen high, and only once three post-reset samples
  // exist. Decisions use the calls latched before this edge.
  task automatic model_step(input bit t, input logic [15:0] s);
    logic [15:0] calls;
    logic [15:0] old;
    hist.push_back(s & 16'((32'd1 << NF) - 1));
    if (hist.size() > 4) void'(hist.pop_front());
    calls = (hist.size() == 4) ? (hist[1] & ~hist[0]) : 16'h0;
    old = m_pend;
    case (m_mode)
      M_IDLE: if (t) begin
        if (old[m_floor]) begin
          m_mode = M_DOOR; m_door = DT;
        end else if (any_above(old, m_floor)) begin
          m_mode = M_UP; m_dir = 1'b1;
        end else if (any_below(old, m_floor)) begin
          m_mode = M_DOWN; m_dir = 1'b0;
        end
      end
      M_UP: if (t) begin
        m_floor++;
        if (old[m_floor]) begin
          m_mode = M_DOOR; m_door = DT;
        end else if (!any_above(old, m_floor)) m_mode = M_IDLE;
      end
      M_DOWN: if (t) begin
        m_floor--;
        if (old[m_floor]) begin
          m_mode = M_DOOR; m_door = DT;
        end else if (!any_below(old, m_floor)) m_mode = M_IDLE;
      end
      default: begin
        if (calls[m_floor]) m_door = DT;
        else if (t) begin
          m_door--;
          if (m_door == 0) begin
            if (m_dir) begin
              if (any_above(old, m_floor)) m_mode = M_UP;
              else if (any_below(old, m_floor)) begin m_mode = M_DOWN; m_dir = 1'b0; end
              else m_mode = M_IDLE;
            end else begin
              if (any_below(old, m_floor)) m_mode = M_DOWN;
              else if (any_above(old, m_floor)) begin m_mode = M_UP; m_dir = 1'b1; end
              else m_mode = M_IDLE;
            end
          end
        end
      end
    endcase
    m_pend = old | calls;
    if (m_mode == M_DOOR) m_pend[m_floor] = 1'b0;
  endtask

  task automatic compare_all();
    check_eq("lift_num",  32'(lift_num),  32'(m_floor));
    check_eq("lift_open", 32'(lift_open), 32'(m_mode == M_DOOR));
    check_eq("dir_up",    32'(dir_up),    32'(m_dir));
    check_eq("moving",    32'(moving),    32'(m_mode == M_UP || m_mode == M_DOWN));
    check_eq("pending",   32'(pending),   32'(m_pend));
  endtask

  // Called at a falling edge; drives inputs, advances the model and checks
  // just after the following rising edge, then returns at the next fall.
  task automatic cycle(input bit t);
    tick = t;
    sw   = cur_sw;
    model_step(t, cur_sw);
    @(posedge clk_100MHz);
    #1;
    compare_all();
    @(negedge clk_100MHz);
  endtask

  task automatic do_tick();
    cycle(1'b1);
    cycle(1'b0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    tick  = 1'b0;
    sw    = cur_sw;
    model_reset();
    #1;
    compare_all();
    for (int i = 0; i < n; i++) @(negedge clk_100MHz);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] visits[$];
    bit         dirs[$];
    bit         was_open;
    int         hold;

    rst_n  = 1'b0;
    tick   = 1'b0;
    sw     = '0;
    cur_sw = '0;
    model_reset();
    @(negedge clk_100MHz);

    // Call to floor 5 from reset.
    do_reset(3);
    idle_cycles(4);
    cur_sw = 16'h0020;
    idle_cycles(2);
    check_eq("pend5_not_yet", 32'(pending[5]), 32'd0);
    idle_cycles(1);
    check_eq("pend5_set", 32'(pending[5]), 32'd1);
    for (int i = 0; i < 6; i++) do_tick();
    check_eq("arrive5_floor", 32'(lift_num), 32'd5);
    check_eq("arrive5_open",  32'(lift_open), 32'd1);
    check_eq("arrive5_clear", 32'(pending[5]), 32'd0);
    for (int i = 0; i < 3; i++) do_tick();
    check_eq("door5_closed", 32'(lift_open), 32'd0);
    check_eq("door5_idle",   32'(moving), 32'd0);

    // Call at the car's own floor 0.
    cur_sw = '0;
    do_reset(2);
    idle_cycles(4);
    cur_sw = 16'h0001;
    idle_cycles(3);
    do_tick();
    check_eq("floor0_open",  32'(lift_open), 32'd1);
    check_eq("floor0_stays", 32'(lift_num), 32'd0);

    // Door reload at floor 4.
    cur_sw = '0;
    do_reset(2);
    idle_cycles(4);
    cur_sw = 16'h0010;
    idle_cycles(3);
    for (int i = 0; i < 5; i++) do_tick();
    check_eq("floor4_open", 32'(lift_open), 32'd1);
    do_tick();
    do_tick();
    cur_sw = '0;
    idle_cycles(3);
    cur_sw = 16'h0010;
    idle_cycles(3);
    do_tick();
    do_tick();
    check_eq("reload_still_open", 32'(lift_open), 32'd1);
    check_eq("reload_pend_zero",  32'(pending[4]), 32'd0);
    do_tick();
    check_eq("reload_closed", 32'(lift_open), 32'd0);

    // SCAN order: moving up at floor 5 with calls at 2 and 9.
    cur_sw = '0;
    do_reset(2);
    idle_cycles(4);
    cur_sw = 16'h0200;
    idle_cycles(3);
    for (int i = 0; i < 6; i++) do_tick();
    cur_sw = 16'h0204;
    idle_cycles(3);
    check_eq("scan_at5",     32'(lift_num), 32'd5);
    check_eq("scan_moving",  32'(moving), 32'd1);
    check_eq("scan_pending", 32'(pending), 32'h0204);
    for (int i = 0; i < 60 && visits.size() < 2; i++) begin
      was_open = lift_open;
      do_tick();
      if (lift_open && !was_open) begin
        visits.push_back(lift_num);
        dirs.push_back(dir_up);
      end
    end
    check_eq("scan_stops", 32'(visits.size()), 32'd2);
    if (visits.size() == 2) begin
      check_eq("scan_first",  32'(visits[0]), 32'd9);
      check_eq("scan_second", 32'(visits[1]), 32'd2);
      check_eq("scan_dir2",   32'(dirs[1]), 32'd0);
    end

    // Reset mid-move with a switch held high.
    cur_sw = '0;
    do_reset(2);
    idle_cycles(4);
    cur_sw = 16'h1000;
    idle_cycles(3);
    for (int i = 0; i < 8; i++) do_tick();
    check_eq("midmove_floor7", 32'(lift_num), 32'd7);
    do_reset(3);
    check_eq("rst_pending", 32'(pending), 32'd0);
    check_eq("rst_floor",   32'(lift_num), 32'd0);
    check_eq("rst_dir",     32'(dir_up), 32'd1);
    for (int i = 0; i < 10; i++) do_tick();
    check_eq("held_sw_no_call", 32'(pending), 32'd0);
    check_eq("held_sw_floor",   32'(lift_num), 32'd0);

    // Randomised traffic, with held ticks and the occasional reset.
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) cur_sw ^= 16'(32'd1 << $urandom_range(15));
      if ($urandom_range(1999) == 0) begin
        do_reset(2);
      end else begin
        if (hold == 0 && $urandom_range(40) == 0) hold = $urandom_range(6, 2);
        if (hold > 0) begin
          hold--;
          cycle(1'b1);
        end else begin
          cycle($urandom_range(3) == 0);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
